multicycle_ctrl_fsm: RTL

//  Multi-cycle control unit for the 32-bit CPU datapath. Sequences each instruction through

---
 rtl/cpu_ctrl_pkg.sv | 30 +++
 rtl/ctrl_decode.sv | 66 ++++++
 rtl/multicycle_ctrl_fsm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle CPU control unit
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_RET, CL_ILL
  } instr_class_e;

  localparam logic [1:0] TYPE_R = 2'b00, TYPE_J = 2'b01, TYPE_I = 2'b10, TYPE_S = 2'b11;

  localparam logic [4:0] FN_AND  = 5'd0, FN_ADD  = 5'd1, FN_SUB  = 5'd2, FN_CMP  = 5'd3;
  localparam logic [4:0] FN_J    = 5'd0, FN_JAL  = 5'd1, FN_RET  = 5'd2;
  localparam logic [4:0] FN_ANDI = 5'd0, FN_ADDI = 5'd1, FN_LW   = 5'd2, FN_SW = 5'd3, FN_BEQ = 5'd4;
  localparam logic [4:0] FN_SLL  = 5'd0, FN_SLR  = 5'd1, FN_SLLV = 5'd2, FN_SLRV = 5'd3;

  localparam logic [2:0] ALU_AND = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2,
                         ALU_CMP = 3'd3, ALU_SLL = 3'd4, ALU_SLR = 3'd5;

  localparam logic [1:0] PC_INC = 2'd0, PC_TARGET = 2'd1, PC_STACK = 2'd2;
  localparam logic [1:0] EXT_SA = 2'd0, EXT_IMM14 = 2'd1, EXT_IMM24 = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - instruction type/function to class and ALU/extender selects
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0]   inst_type,
  input  logic [4:0]   inst_function,
  output instr_class_e cls,
  output logic [2:0]   alu_op,
  output logic [1:0]   ex_src,
  output logic         ex_s,
  output logic         alu_src
);

  always_comb begin
    cls     = CL_ILL;
    alu_op  = ALU_AND;
    ex_src  = EXT_SA;
    ex_s    = 1'b0;
    alu_src = 1'b0;
    case (inst_type)
      TYPE_R: begin
        cls = CL_ALU;
        case (inst_function)
          FN_AND:  alu_op = ALU_AND;
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_CMP:  alu_op = ALU_CMP;
          default: cls = CL_ILL;
        endcase
      end
      TYPE_J: begin
        case (inst_function)
          FN_J:    begin cls = CL_J;   ex_src = EXT_IMM24; ex_s = 1'b1; end
          FN_JAL:  begin cls = CL_JAL; ex_src = EXT_IMM24; ex_s = 1'b1; end
          FN_RET:  cls = CL_RET;
          default: cls = CL_ILL;
        endcase
      end
      TYPE_I: begin
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ex_src  = EXT_IMM14;
        ex_s    = 1'b1;
        case (inst_function)
          FN_ANDI: begin cls = CL_ALU; alu_op = ALU_AND; ex_s = 1'b0; end
          FN_ADDI: cls = CL_ALU;
          FN_LW:   cls = CL_LW;
          FN_SW:   cls = CL_SW;
          FN_BEQ:  begin cls = CL_BEQ; alu_op = ALU_SUB; alu_src = 1'b0; end
          default: cls = CL_ILL;
        endcase
      end
      default: begin
        // Immediate shifts take the shift amount from the extender; variable shifts from RS2
        case (inst_function)
          FN_SLL:  begin cls = CL_ALU; alu_op = ALU_SLL; alu_src = 1'b1; end
          FN_SLR:  begin cls = CL_ALU; alu_op = ALU_SLR; alu_src = 1'b1; end
          FN_SLLV: begin cls = CL_ALU; alu_op = ALU_SLL; end
          FN_SLRV: begin cls = CL_ALU; alu_op = ALU_SLR; end
          default: cls = CL_ILL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath selects
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int IMEM_WAIT       = 2,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] inst_type,
  input  logic [4:0] inst_function,
  input  logic       stop_bit,
  input  logic       zero,
  input  logic       st_empty,
  input  logic       st_full,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] PCsrc,
  output logic [1:0] ExSrc,
  output logic       ExS,
  output logic       ALUsrc,
  output logic       RS2src,
  output logic [2:0] ALUop,
  output logic       MemR,
  output logic       MemW,
  output logic       WB,
  output logic       WBdata,
  output logic       StR,
  output logic       StW,
  output logic [2:0] state,
  output logic       illegal,
  output logic       halted
);

  state_e       cur_state, next_state;
  logic [2:0]   wait_cnt;
  logic [1:0]   type_q, dec_type;
  logic [4:0]   fn_q, dec_fn;
  logic         stop_q, dec_stop;
  instr_class_e cls;
  logic [2:0]   dec_alu_op;
  logic [1:0]   dec_ex_src;
  logic         dec_ex_s, dec_alu_src;
  logic         fetch_done, end_instr, taken;

  assign fetch_done = (wait_cnt == 3'(IMEM_WAIT));
  // The IR is valid on the inputs during DECODE; later states use the copy latched there
  assign dec_type   = (cur_state == S_DECODE) ? inst_type     : type_q;
  assign dec_fn     = (cur_state == S_DECODE) ? inst_function : fn_q;
  assign dec_stop   = (cur_state == S_DECODE) ? stop_bit      : stop_q;
  assign state      = cur_state;
  assign halted     = (cur_state == S_HALT);

  ctrl_decode u_decode (
    .inst_type     (dec_type),
    .inst_function (dec_fn),
    .cls           (cls),
    .alu_op        (dec_alu_op),
    .ex_src        (dec_ex_src),
    .ex_s          (dec_ex_s),
    .alu_src       (dec_alu_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      wait_cnt  <= 3'd0;
      type_q    <= 2'd0;
      fn_q      <= 5'd0;
      stop_q    <= 1'b0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= (cur_state == S_FETCH && !fetch_done) ? wait_cnt + 3'd1 : 3'd0;
      if (cur_state == S_DECODE) begin
        type_q <= inst_type;
        fn_q   <= inst_function;
        stop_q <= stop_bit;
      end
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (cur_state)
      S_FETCH:  next_state = fetch_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (cls)
          CL_ILL:                 next_state = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
          CL_J, CL_JAL, CL_RET:   next_state = S_FETCH;
          default:                next_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          CL_BEQ:       next_state = S_FETCH;
          CL_LW, CL_SW: next_state = S_MEM;
          default:      next_state = S_WB;
        endcase
      end
      S_MEM:    next_state = (cls == CL_LW) ? S_WB : S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    PCsrc     = PC_INC;
    ExSrc     = EXT_SA;
    ExS       = 1'b0;
    ALUsrc    = 1'b0;
    RS2src    = 1'b0;
    ALUop     = ALU_AND;
    MemR      = 1'b0;
    MemW      = 1'b0;
    WB        = 1'b0;
    WBdata    = 1'b0;
    StR       = 1'b0;
    StW       = 1'b0;
    illegal   = 1'b0;
    end_instr = 1'b0;
    taken     = 1'b0;
    case (cur_state)
      S_FETCH:  ir_write = fetch_done;
      S_DECODE: begin
        case (cls)
          CL_ILL: begin
            illegal  = 1'b1;
            pc_write = (HALT_ON_ILLEGAL == 0);
          end
          CL_J: begin
            pc_write = 1'b1;
            PCsrc    = PC_TARGET;
            ExSrc    = dec_ex_src;
            ExS      = dec_ex_s;
          end
          CL_JAL: begin
            pc_write = 1'b1;
            if (st_full) illegal = 1'b1;
            else begin
              PCsrc = PC_TARGET;
              ExSrc = dec_ex_src;
              ExS   = dec_ex_s;
              StW   = 1'b1;
            end
          end
          CL_RET: begin
            pc_write = 1'b1;
            if (st_empty) illegal = 1'b1;
            else begin
              PCsrc = PC_STACK;
              StR   = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        ALUop  = dec_alu_op;
        ALUsrc = dec_alu_src;
        ExSrc  = dec_ex_src;
        ExS    = dec_ex_s;
        if (cls == CL_BEQ) begin
          RS2src    = 1'b1;
          end_instr = 1'b1;
          taken     = zero;
        end
      end
      S_MEM: begin
        if (cls == CL_LW) MemR = 1'b1;
        else begin
          RS2src    = 1'b1;
          MemW      = 1'b1;
          end_instr = 1'b1;
        end
      end
      S_WB: begin
        WB        = 1'b1;
        WBdata    = (cls == CL_LW);
        end_instr = 1'b1;
      end
      default: ;
    endcase
    // A stop bit pops the return address unless a taken branch already chose the PC
    if (end_instr) begin
      pc_write = 1'b1;
      if (taken) PCsrc = PC_TARGET;
      else if (dec_stop) begin
        if (st_empty) illegal = 1'b1;
        else begin
          PCsrc = PC_STACK;
          StR   = 1'b1;
        end
      end
    end
  end

endmodule
